// File: rtl/serial_adder.sv
// Multi-cycle adder: STEP bits per clock, LSB slice first, {Cout,Sum} = A + B + Cin.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting A + ~B + 1.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);
    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [STEP:0]      slice_sum;
    logic [N-1:0]       slice_sel;
    logic [WIDTH-1:0]   b_eff;
    logic               carry_init;

    // Operands are shifted right as they are consumed, so the low STEP bits are always the live slice.
    assign slice_sum = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};

    for (genvar gi = 0; gi < N; gi++) begin : g_sel
        assign slice_sel[gi] = (cnt_q == CNT_W'(gi));
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so Cin is replaced by a forced carry of 1.
    assign b_eff      = sub ? ~B : B;
    assign carry_init = sub ? 1'b1 : Cin;
`else
    assign b_eff      = B;
    assign carry_init = Cin;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            RUN: begin
                a_d     = a_q >> STEP;
                b_d     = b_q >> STEP;
                carry_d = slice_sum[STEP];
                for (int i = 0; i < N; i++) begin
                    if (slice_sel[i]) begin
                        sum_d[i*STEP +: STEP] = slice_sum[STEP-1:0];
                    end
                end
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = slice_sum[STEP];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation, which gives back-to-back throughput.
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = b_eff;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (STEP=1,2,8) share stimulus and are checked
// every cycle against a transaction-level model (countdown plus arithmetic result).
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_r = 1'b0;
`endif

    logic [7:0] sum_w  [3];
    logic       cout_w [3];
    logic       busy_w [3];
    logic       done_w [3];

    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        serial_adder #(
            .WIDTH(8),
            .STEP ((gi == 0) ? 1 : (gi == 1) ? 2 : 8)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start),
            .A    (A),
            .B    (B),
            .Cin  (Cin),
`ifdef SERIAL_ADDER_SUB_EN
            .sub  (sub_r),
`endif
            .Sum  (sum_w[gi]),
            .Cout (cout_w[gi]),
            .busy (busy_w[gi]),
            .done (done_w[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int slices_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 1;
    endfunction

    function automatic logic [8:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic c);
`ifdef SERIAL_ADDER_SUB_EN
        if (sub_r) return {1'b0, a} + {1'b0, ~b} + 9'd1;
`endif
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // Model state: cycles remaining, done flag, visible result and in-flight result.
    int         left_m [3] = '{0, 0, 0};
    bit         done_m [3] = '{0, 0, 0};
    logic [8:0] res_m  [3] = '{9'd0, 9'd0, 9'd0};
    logic [8:0] pend_m [3] = '{9'd0, 9'd0, 9'd0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                left_m[i] = 0;
                done_m[i] = 1'b0;
                res_m[i]  = 9'd0;
            end else if (left_m[i] > 0) begin
                left_m[i]--;
                if (left_m[i] == 0) begin
                    done_m[i] = 1'b1;
                    res_m[i]  = pend_m[i];
                    $display("txn inst%0d slices=%0d result=%03h", i, slices_of(i), pend_m[i]);
                end
            end else begin
                done_m[i] = 1'b0;
                if (start) begin
                    pend_m[i] = ref_result(A, B, Cin);
                    res_m[i]  = 9'd0;
                    left_m[i] = slices_of(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(left_m[i] > 0));
                check($sformatf("done%0d", i), 32'(done_w[i]), 32'(done_m[i]));
                if (left_m[i] == 0)
                    check($sformatf("result%0d", i), {23'd0, cout_w[i], sum_w[i]}, {23'd0, res_m[i]});
            end
        end
    end

    task automatic pulse(input logic [7:0] a, input logic [7:0] b, input logic c);
        A = a; B = b; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A   = 8'($urandom);
        B   = 8'($urandom);
        Cin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done_w[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("done0_seen", 32'(done_w[0]), 32'd1);
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        // Carry through every bit.
        pulse(8'hFF, 8'h01, 1'b0);
        wait_done0(cyc);
        check("lat_step1", cyc, 8);
        check("ff01_s1", {23'd0, cout_w[0], sum_w[0]}, 32'h100);
        @(negedge clk);
        check("ff01_s2", {23'd0, cout_w[1], sum_w[1]}, 32'h100);
        check("ff01_s8", {23'd0, cout_w[2], sum_w[2]}, 32'h100);

        pulse(8'hA5, 8'h5A, 1'b1);
        repeat (9) @(negedge clk);
        check("a55a_s1", {23'd0, cout_w[0], sum_w[0]}, 32'h100);
        check("a55a_s2", {23'd0, cout_w[1], sum_w[1]}, 32'h100);
        check("a55a_s8", {23'd0, cout_w[2], sum_w[2]}, 32'h100);

        // Second start lands on the third RUN edge and must be ignored.
        pulse(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        pulse(8'hFF, 8'hFF, 1'b1);
        wait_done0(cyc);
        check("lat_ignored", cyc, 5);
        check("ignore_s1", {23'd0, cout_w[0], sum_w[0]}, 32'h046);
        repeat (2) @(negedge clk);

        // Back-to-back: new start during the DONE cycle.
        pulse(8'($urandom), 8'($urandom), 1'b0);
        wait_done0(cyc);
        pulse(8'h01, 8'h01, 1'b0);
        wait_done0(cyc);
        check("lat_b2b", cyc, 8);
        check("b2b_s1", {23'd0, cout_w[0], sum_w[0]}, 32'h002);
        @(negedge clk);

        // Abort in the middle of a run.
        pulse(8'hFF, 8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_done", 32'(done_w[0]), 32'd0);
        check("abort_res", {23'd0, cout_w[0], sum_w[0]}, 32'h000);
        repeat (12) @(negedge clk);

        // Reset wins over start.
        rst_n = 1'b0; start = 1'b1; A = 8'h33; B = 8'h44;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        check("rst_prio_busy", 32'(busy_w[0]), 32'd0);
        repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        sub_r = 1'b1;
        pulse(8'h05, 8'h07, 1'b0);
        wait_done0(cyc);
        check("sub_5_7", {23'd0, cout_w[0], sum_w[0]}, 32'h0FE);
        @(negedge clk);
        pulse(8'h07, 8'h05, 1'b0);
        wait_done0(cyc);
        check("sub_7_5", {23'd0, cout_w[0], sum_w[0]}, 32'h102);
        @(negedge clk);
        sub_r = 1'b0;
`endif

        // Random traffic: starts while busy, back-to-back, occasional resets.
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 2) == 0);
            A     = 8'($urandom);
            B     = 8'($urandom);
            Cin   = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 63) != 0);
`ifdef SERIAL_ADDER_SUB_EN
            sub_r = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STEP, default 1, giving the number of bits added per clock.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have input start, 1 bit: request to begin an addition.
REQ-006 The block SHALL have input A, WIDTH bits: first operand.
REQ-007 The block SHALL have input B, WIDTH bits: second operand.
REQ-008 The block SHALL have input Cin, 1 bit: carry-in.
REQ-009 The block SHALL have output Sum, WIDTH bits: registered result.
REQ-010 The block SHALL have output Cout, 1 bit: registered carry-out.
REQ-011 The block SHALL have output busy, 1 bit: high while an addition is in progress.
REQ-012 The block SHALL have output done, 1 bit: one-cycle pulse marking Sum/Cout valid.

Function
REQ-013 WIDTH SHALL be an integer multiple of STEP, with 1 <= STEP <= WIDTH; N = WIDTH/STEP is the slice count.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch A, B and Cin, clear the slice counter and enter RUN.
REQ-016 In IDLE or DONE, start=0 SHALL return the FSM to IDLE.
REQ-017 In RUN, each edge SHALL add STEP operand bits plus the carry register, LSB slice first.
REQ-018 In RUN, each edge SHALL write the STEP-bit partial sum into the matching Sum slice and update the carry register.
REQ-019 After the Nth RUN edge the FSM SHALL enter DONE, with Cout equal to the final carry.
REQ-020 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE, which lasts one cycle.
REQ-021 If start is sampled at edge k, done SHALL be high in the cycle after edge k+N; latency is N cycles (1 cycle when STEP=WIDTH).
REQ-022 start while busy=1 SHALL be ignored; the operands in flight SHALL NOT change.
REQ-023 start high during the DONE cycle SHALL be accepted with no idle gap (back-to-back operation).
REQ-024 Sum and Cout SHALL hold their last result until the next accepted start.
REQ-025 On an accepted start, Sum and Cout SHALL be cleared to 0.
REQ-026 Result SHALL equal {Cout,Sum} = A + B + Cin modulo 2^(WIDTH+1).
REQ-027 A, B and Cin changing after the start edge SHALL NOT affect the result.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE, Sum=0, Cout=0, busy=0, done=0, and clear the carry register and slice counter.
REQ-029 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-030 Reset SHALL take priority over start when both are asserted at the same edge.

Configuration
REQ-031 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL add an input port sub, 1 bit, sampled at the accepted start.
REQ-032 With SERIAL_ADDER_SUB_EN defined and sub=1, the block SHALL compute A + ~B + 1 (Cin ignored); Cout=1 SHALL mean no borrow.
REQ-033 With SERIAL_ADDER_SUB_EN defined and sub=0, behaviour SHALL be as REQ-026.
REQ-034 Without SERIAL_ADDER_SUB_EN, port sub SHALL be absent and the block SHALL only add.

Verification
REQ-035 WIDTH=8, STEP=1, A=0xFF, B=0x01, Cin=0, start one cycle -> busy high 8 cycles, then done pulse with Sum=0x00, Cout=1.
REQ-036 WIDTH=8, STEP=2, A=0xA5, B=0x5A, Cin=1 -> done 4 cycles after start, Sum=0x00, Cout=1; WIDTH=8, STEP=8, same operands -> done 1 cycle after start, same result.
REQ-037 WIDTH=8, STEP=1, A=0x12, B=0x34 started, then start pulsed with A=0xFF, B=0xFF at RUN cycle 3 -> second start ignored, done with Sum=0x46, Cout=0.
REQ-038 start held high across DONE with new operands A=0x01, B=0x01 -> second operation begins at that edge, with its own done pulse 8 cycles later, Sum=0x02.
REQ-039 rst_n=0 at RUN cycle 4 -> next cycle busy=0, done=0, Sum=0, Cout=0, and no done pulse afterwards.
REQ-040 With SERIAL_ADDER_SUB_EN: A=0x05, B=0x07, sub=1 -> Sum=0xFE, Cout=0; A=0x07, B=0x05, sub=1 -> Sum=0x02, Cout=1.
